regfile_uart_dump: RTL

Debug reader for the general-purpose register file. On a start pulse it walks all registers through a spare read port. It transmits each register's value MSB-byte-first over a UART 8N1 serial line, preceded by one header byte. It sits beside the register file on the board and uses the read-enable/read-address/read-data port with the same semantics as the decode-stage read ports.

---
 rtl/regfile_uart_dump.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/regfile_uart_dump.sv
`default_nettype none
// ============================================================================
// Module      : regfile_uart_dump
// Description : Debug reader for the general-purpose register file. A start
//               pulse walks every register through a spare read port and
//               streams a header byte followed by each register value,
//               MSB byte first, over a UART 8N1 line.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_uart_dump #(
  parameter int         CLK_DIV    = 434,    // clock cycles per UART bit, 2..65535
  parameter int         REG_NUM    = 32,     // number of registers dumped
  parameter int         REG_ADDR_W = 5,      // register address width
  parameter int         DATA_W     = 32,     // register width, multiple of 8
  parameter logic [7:0] HEADER     = 8'hA5   // frame header byte
) (
  input  logic                  clk,
  input  logic                  rst,         // asynchronous, active-low
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  re_o,
  output logic [REG_ADDR_W-1:0] raddr_o,
  input  logic [DATA_W-1:0]     rdata_i,
  output logic                  txd_o
);

  // Counter sizing: every counter holds exactly its terminal value and is
  // reloaded explicitly, never allowed to wrap on its own.
  localparam int BYTES  = DATA_W / 8;
  localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BYTE_W = (BYTES > 1)   ? $clog2(BYTES)   : 1;
  localparam int IDX_W  = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(REG_NUM - 1);
  localparam logic [3:0]        BIT_DATA7 = 4'd8;  // last data bit slot
  localparam logic [3:0]        BIT_STOP  = 4'd9;  // stop bit slot

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  logic [BAUD_W-1:0]   baud_cnt;   // cycles elapsed in the current bit
  logic [3:0]          bit_cnt;    // 0 = start, 1..8 = data, 9 = stop
  logic [BYTE_W-1:0]   byte_cnt;   // bytes of the current word already sent
  logic [IDX_W-1:0]    reg_idx;    // register currently being dumped
  logic [7:0]          tx_shift;   // remaining data bits of the byte on the line
  logic [DATA_W-1:0]   word_rest;  // not-yet-sent bytes of the latched word, MSB aligned
  logic                hdr_phase;  // the byte on the line is the header

  logic [IDX_W-1:0]    reg_idx_next;
  logic                bit_end;
  logic                byte_end;

  assign reg_idx_next = reg_idx + IDX_W'(1);
  assign bit_end      = (baud_cnt == BAUD_LAST);
  assign byte_end     = bit_end && (bit_cnt == BIT_STOP);

  // Frame sequencer: all outputs are registered here so the line and the
  // read port change only on clock edges (reset excepted).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      txd_o     <= 1'b1;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      re_o      <= 1'b0;
      raddr_o   <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      reg_idx   <= '0;
      tx_shift  <= '0;
      word_rest <= '0;
      hdr_phase <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          txd_o   <= 1'b1;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
          re_o    <= 1'b0;
          raddr_o <= '0;
          if (start_i) begin
            // Start bit goes out on the very first SEND cycle.
            state     <= SEND;
            busy_o    <= 1'b1;
            txd_o     <= 1'b0;
            tx_shift  <= HEADER;
            hdr_phase <= 1'b1;
            reg_idx   <= '0;
            byte_cnt  <= '0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
          end
        end

        SEND: begin
          if (!bit_end) begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end else if (!byte_end) begin
            // Advance to the next bit slot of this byte.
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == BIT_DATA7) begin
              txd_o <= 1'b1;
            end else begin
              txd_o    <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            // Stop bit finished: pick what follows this byte.
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (hdr_phase) begin
              hdr_phase <= 1'b0;
              state     <= READ;
              re_o      <= 1'b1;
              raddr_o   <= REG_ADDR_W'(reg_idx);
            end else if (byte_cnt != BYTE_LAST) begin
              byte_cnt  <= byte_cnt + BYTE_W'(1);
              tx_shift  <= word_rest[DATA_W-1 -: 8];
              word_rest <= word_rest << 8;
              txd_o     <= 1'b0;
            end else if (reg_idx != IDX_LAST) begin
              reg_idx  <= reg_idx_next;
              byte_cnt <= '0;
              state    <= READ;
              re_o     <= 1'b1;
              raddr_o  <= REG_ADDR_W'(reg_idx_next);
            end else begin
              byte_cnt <= '0;
              reg_idx  <= '0;
              state    <= DONE;
              busy_o   <= 1'b0;
              done_o   <= 1'b1;
            end
          end
        end

        READ: begin
          // Single-cycle read; whatever the register file presents now
          // (forwarded write data, hardwired zero) is what gets dumped.
          re_o      <= 1'b0;
          raddr_o   <= '0;
          tx_shift  <= rdata_i[DATA_W-1 -: 8];
          word_rest <= rdata_i << 8;
          byte_cnt  <= '0;
          baud_cnt  <= '0;
          bit_cnt   <= '0;
          txd_o     <= 1'b0;
          state     <= SEND;
        end

        DONE: begin
          // start_i is deliberately not looked at here.
          done_o <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state  <= IDLE;
          txd_o  <= 1'b1;
          busy_o <= 1'b0;
          done_o <= 1'b0;
          re_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
